// File: rtl/dct_arb_pkg.sv
// Shared types and helpers for the DCT source arbiter: FSM states, source
// count and the mux4to1 select encoding.
package dct_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int N_SRC         = 4;
    localparam int BLOCK_LEN_DEF = 8;

    // The shared mux4to1 numbers its inputs in reverse order.
    function automatic logic [1:0] src2sel(input logic [1:0] i);
        return ~i;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning last+1, +2,
// +3, +0 (mod 4), so the previous owner has the lowest priority.
module rr_pick4
    import dct_arb_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [1:0]       last,
    output logic             any,
    output logic [1:0]       idx
);

    logic [1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = last;
        cand = last;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = last + 2'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/dct_src_arbiter.sv
// Round-robin sequencer sharing one DCT input path among four sample sources;
// each grant lasts one BLOCK_LEN-sample block with valid/first/last framing.
module dct_src_arbiter
    import dct_arb_pkg::*;
#(
    parameter int BLOCK_LEN = BLOCK_LEN_DEF,
    parameter int CNT_W     = $clog2(BLOCK_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    input  logic             abort,
    input  logic             out_ready,
    output logic [N_SRC-1:0] grant,
    output logic [1:0]       sel,
    output logic [N_SRC-1:0] src_ack,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

    arb_state_e       state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_owner_q, last_owner_d;

    logic [1:0] owner_idx;
    logic [1:0] pick_last;
    logic       pick_any;
    logic [1:0] pick_idx;
    logic       beat;

    // While busy, sel always holds the owner's encoding, so it doubles as the owner index.
    assign owner_idx = ~sel_q;
    assign pick_last = (state_q == XFER) ? owner_idx : last_owner_q;

    rr_pick4 u_pick (
        .req  (req),
        .last (pick_last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        out_valid = (state_q == XFER) && req[owner_idx];
        beat      = out_valid && out_ready;
        out_first = out_valid && (cnt_q == '0);
        out_last  = out_valid && (cnt_q == CNT_LAST);
        src_ack   = grant_q & {N_SRC{beat}};
        busy      = (state_q == XFER);
        grant     = grant_q;
        sel       = sel_q;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;

        if (abort) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (pick_any) begin
                state_d = XFER;
                grant_d = {{(N_SRC-1){1'b0}}, 1'b1} << pick_idx;
                sel_d   = src2sel(pick_idx);
                cnt_d   = '0;
            end
        end else if (beat) begin
            if (cnt_q == CNT_LAST) begin
                // Re-arbitrate on the closing beat so back-to-back blocks have no bubble.
                last_owner_d = owner_idx;
                cnt_d        = '0;
                if (pick_any) begin
                    grant_d = {{(N_SRC-1){1'b0}}, 1'b1} << pick_idx;
                    sel_d   = src2sel(pick_idx);
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            sel_q        <= 2'b11;
            cnt_q        <= '0;
            last_owner_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule
